// File: rtl/timing_sequencer_if.sv
// Bus between the CPU control path and the T-state sequencer.
// The master drives the opcode and run/step controls; the slave (the sequencer)
// drives the one-hot T-state strobes and the retire/halt/count status.
interface timing_sequencer_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       opcode;
    logic             run_en;
    logic             step_mode;
    logic             step_req;
    logic             t0;
    logic             t1;
    logic             t2;
    logic             t3;
    logic             t4;
    logic             t5;
    logic             instr_done;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output opcode, run_en, step_mode, step_req,
        input  t0, t1, t2, t3, t4, t5, instr_done, halted, instr_count
    );

    modport slave (
        input  opcode, run_en, step_mode, step_req,
        output t0, t1, t2, t3, t4, t5, instr_done, halted, instr_count
    );
endinterface

// File: rtl/timing_sequencer.sv
// T-state generator for the 8-bit CPU.
// Produces one-hot t0..t5 strobes, shortens the machine cycle per opcode,
// freezes on HALT, supports pause (run_en) and single-step (step_mode/step_req),
// and counts retired instructions.
module timing_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    timing_sequencer_if.slave   bus
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t           state_q,      state_d;
    logic [5:0]       t_q,          t_d;
    logic             instr_done_q, instr_done_d;
    logic             halted_q,     halted_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             step_req_q,   step_req_d;
    logic             adv;
    logic             at_last;

    // Mask of T-states at or beyond the last T-state of the given opcode.
    // An advance from any of these states ends the instruction, which also
    // covers a short opcode appearing late (at t4/t5) in the cycle.
    function automatic logic [5:0] last_mask(input logic [3:0] op);
        logic [5:0] m;
        case (op)
            4'b0000, 4'b0011, 4'b0100, 4'b0110: m = 6'b100000;
            4'b0111:                            m = 6'b110000;
            default:                            m = 6'b111000;
        endcase
        return m;
    endfunction

    // Next-state logic: advance enable, one-hot shift, retire and halt decisions.
    always_comb begin
        adv          = bus.run_en & (~bus.step_mode | (bus.step_req & ~step_req_q));
        at_last      = |(t_q & last_mask(bus.opcode));
        step_req_d   = bus.step_req;
        state_d      = state_q;
        t_d          = t_q;
        instr_done_d = 1'b0;
        halted_d     = halted_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_RUN: begin
                if (adv) begin
                    if (t_q[2] && (bus.opcode == OP_HLT)) begin
                        state_d      = ST_HALTED;
                        t_d          = 6'b000000;
                        halted_d     = 1'b1;
                        instr_done_d = 1'b1;
                        cnt_d        = cnt_q + CNT_W'(1);
                    end else if (at_last) begin
                        t_d          = 6'b000001;
                        instr_done_d = 1'b1;
                        cnt_d        = cnt_q + CNT_W'(1);
                    end else begin
                        t_d = {t_q[4:0], 1'b0};
                    end
                end
            end
            default: begin
                // HALTED is sticky; only reset leaves it.
                t_d = 6'b000000;
            end
        endcase
    end

    // Sequencer FSM and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            t_q          <= 6'b000001;
            instr_done_q <= 1'b0;
            halted_q     <= 1'b0;
            cnt_q        <= '0;
            step_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            instr_done_q <= instr_done_d;
            halted_q     <= halted_d;
            cnt_q        <= cnt_d;
            step_req_q   <= step_req_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        bus.t0          = t_q[0];
        bus.t1          = t_q[1];
        bus.t2          = t_q[2];
        bus.t3          = t_q[3];
        bus.t4          = t_q[4];
        bus.t5          = t_q[5];
        bus.instr_done  = instr_done_q;
        bus.halted      = halted_q;
        bus.instr_count = cnt_q;
    end

endmodule

// File: tb/tb_timing_sequencer.sv
// Scoreboard bench for timing_sequencer: directed scenarios followed by
// randomized traffic, checked against a T-state reference model.
module tb_timing_sequencer;

    localparam int CNT_W = 8;

    typedef struct {
        logic [5:0]       t;
        logic             done;
        logic             halted;
        logic [CNT_W-1:0] count;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    timing_sequencer_if #(.CNT_W(CNT_W)) bus ();

    timing_sequencer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: the active T-state as a plain number.
    int               m_tstate;
    bit               m_halted;
    logic [CNT_W-1:0] m_count;
    bit               m_prev_sr;

    function automatic int instr_len(input logic [3:0] op);
        if (op == 4'd0 || op == 4'd3 || op == 4'd4 || op == 4'd6) return 6;
        if (op == 4'd7) return 5;
        return 4;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the response
    // the sequencer must show after the following rising edge.
    task automatic cyc(input logic [3:0] op, input bit run, input bit sm,
                       input bit sr, input bit rst);
        exp_t e;
        bit   adv;
        bit   done;
        @(negedge clk);
        bus.opcode    = op;
        bus.run_en    = run;
        bus.step_mode = sm;
        bus.step_req  = sr;
        reset         = rst;
        done = 1'b0;
        if (rst) begin
            m_tstate  = 0;
            m_halted  = 1'b0;
            m_count   = '0;
            m_prev_sr = 1'b0;
        end else begin
            adv = run && (!sm || (sr && !m_prev_sr));
            m_prev_sr = sr;
            if (!m_halted && adv) begin
                if (m_tstate == 2 && op == 4'hF) begin
                    m_halted = 1'b1;
                    done     = 1'b1;
                    m_count  = m_count + 1'b1;
                end else if (m_tstate + 1 >= instr_len(op)) begin
                    m_tstate = 0;
                    done     = 1'b1;
                    m_count  = m_count + 1'b1;
                end else begin
                    m_tstate = m_tstate + 1;
                end
            end
        end
        e.t      = m_halted ? 6'b0 : 6'(1 << m_tstate);
        e.done   = done;
        e.halted = m_halted;
        e.count  = m_count;
        exp_q.push_back(e);
    endtask

    // Monitor: after every rising edge, compare the DUT against the oldest
    // queued expectation.
    initial begin
        exp_t       e;
        logic [5:0] t_act;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                t_act = {bus.t5, bus.t4, bus.t3, bus.t2, bus.t1, bus.t0};
                n_tests++;
                if (t_act !== e.t) begin
                    n_fail++;
                    $display("FAIL tstate at %0t: got %b expected %b", $time, t_act, e.t);
                end
                n_tests++;
                if (bus.instr_done !== e.done) begin
                    n_fail++;
                    $display("FAIL instr_done at %0t: got %b expected %b", $time, bus.instr_done, e.done);
                end
                n_tests++;
                if (bus.halted !== e.halted) begin
                    n_fail++;
                    $display("FAIL halted at %0t: got %b expected %b", $time, bus.halted, e.halted);
                end
                n_tests++;
                if (bus.instr_count !== e.count) begin
                    n_fail++;
                    $display("FAIL instr_count at %0t: got %0d expected %0d", $time, bus.instr_count, e.count);
                end
            end
        end
    end

    initial begin
        bus.opcode    = 4'd0;
        bus.run_en    = 1'b0;
        bus.step_mode = 1'b0;
        bus.step_req  = 1'b0;
        reset         = 1'b1;
        m_tstate  = 0;
        m_halted  = 1'b0;
        m_count   = '0;
        m_prev_sr = 1'b0;

        // Free-running ADD: period 6, three retirements in 18 cycles.
        cyc(4'd3, 1, 0, 0, 1);
        for (int i = 0; i < 18; i++) cyc(4'd3, 1, 0, 0, 0);

        // Shorter cycles: OUT, JMP, other opcode.
        for (int i = 0; i < 8; i++)  cyc(4'd14, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(4'd7, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++)  cyc(4'd5, 1, 0, 0, 0);

        // HALT, then sticky against toggling controls, then reset out.
        cyc(4'd15, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(4'd15, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            cyc(4'($urandom_range(0, 15)), i[0], i[1], i[2], 0);
        cyc(4'd0, 1, 0, 0, 1);
        cyc(4'd0, 1, 0, 0, 0);

        // Single-step: held request is one advance, pulses advance once each,
        // a pulse with run_en low is dropped.
        cyc(4'd0, 1, 1, 0, 1);
        for (int i = 0; i < 10; i++) cyc(4'd0, 1, 1, 1, 0);
        cyc(4'd0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(4'd0, 1, 1, 1, 0);
            cyc(4'd0, 1, 1, 0, 0);
        end
        cyc(4'd0, 0, 1, 1, 0);
        cyc(4'd0, 0, 1, 0, 0);

        // Pause at t4, then resume to t5 and retire.
        for (int i = 0; i < 5; i++) cyc(4'd0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(4'd0, 1, 0, 0, 0);

        // Counter wrap over 256 four-state instructions.
        cyc(4'd14, 1, 0, 0, 1);
        for (int i = 0; i < 256 * 4 + 2; i++) cyc(4'd14, 1, 0, 0, 0);

        // Reset in the middle of an ADD at t3.
        cyc(4'd3, 1, 0, 0, 1);
        for (int i = 0; i < 9; i++) cyc(4'd3, 1, 0, 0, 0);
        cyc(4'd3, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(4'd3, 1, 0, 0, 0);

        // Randomized traffic; halts are rare so RUN gets most of the time.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h3;
            cyc(op, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
